// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the instruction fetch front-end: PC geometry and the
// PC -> {X,Y} mapping used by the fetch unit, the memory loader and the bench.
package cpu_fetch_pkg;

    localparam int PC_WIDTH   = 32;
    localparam int INST_ALIGN = 2;
    localparam int IDX_BITS   = PC_WIDTH - INST_ALIGN;

    // Word index of a byte PC folded onto a 2^(2*addr_bits)-word array.
    // The result is {X,Y} right-aligned; upper PC bits alias (wrap) away.
    function automatic logic [IDX_BITS-1:0] pc_to_xy(input logic [PC_WIDTH-1:0] pc,
                                                     input int addr_bits);
        logic [IDX_BITS-1:0] mask;
        mask = '1;
        mask = mask >> (IDX_BITS - 2 * addr_bits);
        return pc[PC_WIDTH-1:INST_ALIGN] & mask;
    endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO between the memory response stage and decode.
// Entry 0 is always the head, so the head data is a plain register output and
// stays stable until it is popped.
module fetch_skid_fifo #(
    parameter int WIDTH = 64
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;

    // Storage and occupancy update; Reset beats flush, flush beats push/pop.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            // NOTE: the two entries are ordinary flops, not a RAM macro, so they
            // can be reset; this is what makes the Inst_* outputs read zero after Reset.
            count  <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) entry0 <= push_data;
                    else               entry1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind the survivor.
                    if (count == 2'd2) begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end else begin
                        entry0 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_data = entry0;

    // The issue throttle upstream guarantees a push never meets a full FIFO.
    no_push_when_full: assert property (@(posedge Clock) disable iff (Reset)
        !(push && !flush && count == 2'd2));

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch front-end for the 2D-addressed instruction memory.
// Holds the fetch PC, drives X/Y addresses, tracks the one-cycle read latency
// and hands instructions to decode through a 2-entry skid FIFO.
module imem_fetch
    import cpu_fetch_pkg::*;
#(
    parameter int          ADDR_BITS  = 4,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Redirect_valid,
    input  logic [PC_WIDTH-1:0]   Redirect_pc,
    output logic                  Mem_WriteEnable,
    output logic [ADDR_BITS-1:0]  Mem_X_addr,
    output logic [ADDR_BITS-1:0]  Mem_Y_addr,
    input  logic [DATA_WIDTH-1:0] Mem_Data_out,
    output logic                  Inst_valid,
    input  logic                  Inst_ready,
    output logic [DATA_WIDTH-1:0] Inst_data,
    output logic [PC_WIDTH-1:0]   Inst_pc
);

    localparam int XY_BITS    = 2 * ADDR_BITS;
    localparam int ENTRY_BITS = PC_WIDTH + DATA_WIDTH;

    logic [PC_WIDTH-1:0]   fetch_pc;
    logic [PC_WIDTH-1:0]   resp_pc;
    logic                  resp_valid;
    logic                  issue;
    logic                  pop;
    logic                  flush;
    logic [1:0]            fifo_count;
    logic [2:0]            occupancy;
    logic [XY_BITS-1:0]    word_xy;
    logic [ENTRY_BITS-1:0] head_entry;
    logic                  unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^Redirect_pc[INST_ALIGN-1:0];

    // The memory reads every cycle from the current fetch PC; we only decide
    // which responses to keep.
    assign Mem_WriteEnable = 1'b0;
    assign word_xy         = XY_BITS'(pc_to_xy(fetch_pc, ADDR_BITS));
    assign Mem_X_addr      = word_xy[XY_BITS-1:ADDR_BITS];
    assign Mem_Y_addr      = word_xy[ADDR_BITS-1:0];

    // A redirect/reset cycle hides the head so no stale handshake can complete.
    assign flush      = Redirect_valid;
    assign Inst_valid = (fifo_count != 2'd0) && !Redirect_valid && !Reset;
    assign pop        = Inst_valid && Inst_ready;

    // Entries already owned after this cycle: buffered + in flight - leaving.
    // Issuing is safe only if that leaves room for the new word.
    assign occupancy = {1'b0, fifo_count} + {2'b00, resp_valid} - {2'b00, pop};
    assign issue     = !Reset && !Redirect_valid && (occupancy <= 3'd1);

    // Fetch PC and in-flight response tracking; Reset beats redirect.
    always_ff @(posedge Clock) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values,
        // e.g. resp_pc captures the PC that was actually issued, not PC+4.
        if (Reset) begin
            fetch_pc   <= RESET_PC;
            resp_valid <= 1'b0;
            resp_pc    <= '0;
        end else if (Redirect_valid) begin
            fetch_pc   <= {Redirect_pc[PC_WIDTH-1:INST_ALIGN], {INST_ALIGN{1'b0}}};
            resp_valid <= 1'b0;
        end else begin
            resp_valid <= issue;
            if (issue) begin
                resp_pc  <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    fetch_skid_fifo #(
        .WIDTH (ENTRY_BITS)
    ) u_skid (
        .Clock     (Clock),
        .Reset     (Reset),
        .push      (resp_valid),
        .pop       (pop),
        .flush     (flush),
        .push_data ({resp_pc, Mem_Data_out}),
        .head_data (head_entry),
        .count     (fifo_count)
    );

    assign Inst_pc   = head_entry[ENTRY_BITS-1:DATA_WIDTH];
    assign Inst_data = head_entry[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch with a registered-read 16x16 memory model.
// Memory word i holds 32'hC0DE_0000 + i, so mem[x][y] = C0DE_0000 + 16*x + y.
module tb_imem_fetch;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Redirect_valid = 1'b0;
    logic [31:0] Redirect_pc = 32'h0;
    logic        Mem_WriteEnable;
    logic [3:0]  Mem_X_addr;
    logic [3:0]  Mem_Y_addr;
    logic [31:0] Mem_Data_out = 32'h0;
    logic        Inst_valid;
    logic        Inst_ready = 1'b1;
    logic [31:0] Inst_data;
    logic [31:0] Inst_pc;

    logic [31:0] mem [0:255];

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    imem_fetch #(
        .ADDR_BITS  (4),
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .Redirect_valid  (Redirect_valid),
        .Redirect_pc     (Redirect_pc),
        .Mem_WriteEnable (Mem_WriteEnable),
        .Mem_X_addr      (Mem_X_addr),
        .Mem_Y_addr      (Mem_Y_addr),
        .Mem_Data_out    (Mem_Data_out),
        .Inst_valid      (Inst_valid),
        .Inst_ready      (Inst_ready),
        .Inst_data       (Inst_data),
        .Inst_pc         (Inst_pc)
    );

    // Registered-read memory: data for the address seen at an edge appears after it.
    always @(posedge Clock) Mem_Data_out <= mem[{Mem_X_addr, Mem_Y_addr}];

    // Move to just after the next rising edge (start of the next cycle).
    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    // Let combinational outputs react to inputs driven this cycle.
    task automatic settle();
        #1;
    endtask

    // One reset cycle, then return in cycle 1 with Inst_ready=1.
    task automatic restart();
        next_cycle();
        Reset = 1'b1; Redirect_valid = 1'b0; Inst_ready = 1'b1;
        next_cycle();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Redirect_valid = 1'b0; Inst_ready = 1'b1;
        next_cycle();
        Reset = 1'b1;
        settle();
        checks++;
        if (Inst_valid !== 1'b0) begin
            errors++; $display("FAIL reset_c0_valid: got %b want 0", Inst_valid);
        end
        next_cycle();
        Reset = 1'b0;
        settle();
        checks++;
        if ({Inst_valid, Inst_pc, Inst_data} !== {1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_values: got v=%b pc=%h d=%h want v=0 pc=0 d=0",
                     Inst_valid, Inst_pc, Inst_data);
        end
        checks++;
        if ({Mem_WriteEnable, Mem_X_addr, Mem_Y_addr} !== 9'h0) begin
            errors++;
            $display("FAIL reset_mem_if: got we=%b x=%h y=%h want we=0 x=0 y=0",
                     Mem_WriteEnable, Mem_X_addr, Mem_Y_addr);
        end
        next_cycle();
        settle();
        checks++;
        if (Inst_valid !== 1'b0) begin
            errors++; $display("FAIL reset_c2_valid: got %b want 0", Inst_valid);
        end
    endtask

    // Continues from test_reset (now in cycle 2): A0..A3 on cycles 3..6.
    task automatic test_stream();
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            settle();
            checks++;
            if ({Inst_valid, Inst_pc, Inst_data} !==
                {1'b1, 32'(4 * k), 32'hC0DE_0000 + 32'(k)}) begin
                errors++;
                $display("FAIL stream_%0d: got v=%b pc=%h d=%h want v=1 pc=%h d=%h",
                         k, Inst_valid, Inst_pc, Inst_data, 32'(4 * k),
                         32'hC0DE_0000 + 32'(k));
            end
        end
    endtask

    task automatic test_backpressure();
        restart();
        repeat (3) next_cycle();
        // cycle 4: A1 at head, drop ready for cycles 4..8
        Inst_ready = 1'b0;
        settle();
        checks++;
        if ({Inst_valid, Inst_pc, Inst_data, Mem_Y_addr} !== {1'b1, 32'h4, 32'hC0DE_0001, 4'h3}) begin
            errors++;
            $display("FAIL bp_c4: got v=%b pc=%h d=%h y=%h want v=1 pc=4 d=c0de0001 y=3",
                     Inst_valid, Inst_pc, Inst_data, Mem_Y_addr);
        end
        for (int c = 5; c <= 8; c++) begin
            next_cycle();
            settle();
            checks++;
            if ({Inst_valid, Inst_pc, Inst_data} !== {1'b1, 32'h4, 32'hC0DE_0001}) begin
                errors++;
                $display("FAIL bp_hold_c%0d: got v=%b pc=%h d=%h want v=1 pc=4 d=c0de0001",
                         c, Inst_valid, Inst_pc, Inst_data);
            end
            checks++;
            if ({Mem_X_addr, Mem_Y_addr, dut.fifo_count} !== {4'h0, 4'h3, 2'd2}) begin
                errors++;
                $display("FAIL bp_freeze_c%0d: got x=%h y=%h cnt=%0d want x=0 y=3 cnt=2",
                         c, Mem_X_addr, Mem_Y_addr, dut.fifo_count);
            end
        end
        next_cycle();
        Inst_ready = 1'b1;
        settle();
        checks++;
        if ({Inst_valid, Inst_pc, Inst_data} !== {1'b1, 32'h4, 32'hC0DE_0001}) begin
            errors++;
            $display("FAIL bp_release: got v=%b pc=%h d=%h want v=1 pc=4 d=c0de0001",
                     Inst_valid, Inst_pc, Inst_data);
        end
        for (int k = 2; k <= 4; k++) begin
            next_cycle();
            settle();
            checks++;
            if ({Inst_valid, Inst_pc, Inst_data} !==
                {1'b1, 32'(4 * k), 32'hC0DE_0000 + 32'(k)}) begin
                errors++;
                $display("FAIL bp_resume_%0d: got v=%b pc=%h d=%h want v=1 pc=%h d=%h",
                         k, Inst_valid, Inst_pc, Inst_data, 32'(4 * k),
                         32'hC0DE_0000 + 32'(k));
            end
        end
    endtask

    task automatic test_redirect();
        restart();
        repeat (4) next_cycle();
        // cycle 5 of the stream becomes redirect cycle 0
        Redirect_valid = 1'b1; Redirect_pc = 32'h46;
        settle();
        checks++;
        if (Inst_valid !== 1'b0) begin
            errors++; $display("FAIL redir_c0_valid: got %b want 0", Inst_valid);
        end
        next_cycle();
        Redirect_valid = 1'b0;
        settle();
        checks++;
        if ({Inst_valid, Mem_X_addr, Mem_Y_addr} !== {1'b0, 4'h1, 4'h1}) begin
            errors++;
            $display("FAIL redir_c1: got v=%b x=%h y=%h want v=0 x=1 y=1",
                     Inst_valid, Mem_X_addr, Mem_Y_addr);
        end
        next_cycle();
        settle();
        checks++;
        if (Inst_valid !== 1'b0) begin
            errors++; $display("FAIL redir_c2_valid: got %b want 0", Inst_valid);
        end
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            settle();
            checks++;
            if ({Inst_valid, Inst_pc, Inst_data} !==
                {1'b1, 32'h44 + 32'(4 * k), 32'hC0DE_0011 + 32'(k)}) begin
                errors++;
                $display("FAIL redir_seq_%0d: got v=%b pc=%h d=%h want v=1 pc=%h d=%h",
                         k, Inst_valid, Inst_pc, Inst_data, 32'h44 + 32'(4 * k),
                         32'hC0DE_0011 + 32'(k));
            end
        end
    endtask

    task automatic test_wrap();
        restart();
        next_cycle();
        Redirect_valid = 1'b1; Redirect_pc = 32'h3FC;
        next_cycle();
        Redirect_valid = 1'b0;
        settle();
        checks++;
        if ({Mem_X_addr, Mem_Y_addr} !== 8'hFF) begin
            errors++; $display("FAIL wrap_addr_3fc: got x=%h y=%h want x=f y=f", Mem_X_addr, Mem_Y_addr);
        end
        next_cycle();
        settle();
        checks++;
        if ({Mem_X_addr, Mem_Y_addr} !== 8'h00) begin
            errors++; $display("FAIL wrap_addr_400: got x=%h y=%h want x=0 y=0", Mem_X_addr, Mem_Y_addr);
        end
        next_cycle();
        settle();
        checks++;
        if ({Inst_valid, Inst_pc, Inst_data} !== {1'b1, 32'h3FC, 32'hC0DE_00FF}) begin
            errors++;
            $display("FAIL wrap_3fc: got v=%b pc=%h d=%h want v=1 pc=3fc d=c0de00ff",
                     Inst_valid, Inst_pc, Inst_data);
        end
        next_cycle();
        settle();
        checks++;
        if ({Inst_valid, Inst_pc, Inst_data} !== {1'b1, 32'h400, 32'hC0DE_0000}) begin
            errors++;
            $display("FAIL wrap_400: got v=%b pc=%h d=%h want v=1 pc=400 d=c0de0000",
                     Inst_valid, Inst_pc, Inst_data);
        end
    endtask

    task automatic test_full_redirect();
        restart();
        repeat (2) next_cycle();
        // cycle 3: stall one cycle so the FIFO fills to 2
        Inst_ready = 1'b0;
        next_cycle();
        Inst_ready = 1'b1; Redirect_valid = 1'b1; Redirect_pc = 32'h100;
        settle();
        checks++;
        if (Inst_valid !== 1'b0 || dut.fifo_count !== 2'd2) begin
            errors++;
            $display("FAIL full_redir_c0: got v=%b cnt=%0d want v=0 cnt=2",
                     Inst_valid, dut.fifo_count);
        end
        next_cycle();
        Redirect_valid = 1'b0;
        settle();
        checks++;
        if (Inst_valid !== 1'b0 || dut.fifo_count !== 2'd0) begin
            errors++;
            $display("FAIL full_redir_c1: got v=%b cnt=%0d want v=0 cnt=0",
                     Inst_valid, dut.fifo_count);
        end
        next_cycle();
        settle();
        checks++;
        if (Inst_valid !== 1'b0) begin
            errors++; $display("FAIL full_redir_c2: got v=%b want 0", Inst_valid);
        end
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            settle();
            checks++;
            if ({Inst_valid, Inst_pc, Inst_data} !==
                {1'b1, 32'h100 + 32'(4 * k), 32'hC0DE_0040 + 32'(k)}) begin
                errors++;
                $display("FAIL full_redir_seq_%0d: got v=%b pc=%h d=%h want v=1 pc=%h d=%h",
                         k, Inst_valid, Inst_pc, Inst_data, 32'h100 + 32'(4 * k),
                         32'hC0DE_0040 + 32'(k));
            end
        end
    endtask

    task automatic test_reset_priority();
        restart();
        repeat (3) next_cycle();
        // cycle 4: reset, redirect and stall together
        Inst_ready = 1'b0; Reset = 1'b1; Redirect_valid = 1'b1; Redirect_pc = 32'h80;
        settle();
        checks++;
        if (Inst_valid !== 1'b0) begin
            errors++; $display("FAIL rst_prio_c0: got v=%b want 0", Inst_valid);
        end
        next_cycle();
        Reset = 1'b0; Redirect_valid = 1'b0; Inst_ready = 1'b1;
        settle();
        checks++;
        if ({Inst_valid, Inst_pc, Inst_data, Mem_X_addr, Mem_Y_addr} !==
            {1'b0, 32'h0, 32'h0, 4'h0, 4'h0}) begin
            errors++;
            $display("FAIL rst_prio_c1: got v=%b pc=%h d=%h x=%h y=%h want v=0 pc=0 d=0 x=0 y=0",
                     Inst_valid, Inst_pc, Inst_data, Mem_X_addr, Mem_Y_addr);
        end
        next_cycle();
        settle();
        checks++;
        if (Inst_valid !== 1'b0) begin
            errors++; $display("FAIL rst_prio_c2: got v=%b want 0", Inst_valid);
        end
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            settle();
            checks++;
            if ({Inst_valid, Inst_pc, Inst_data} !==
                {1'b1, 32'(4 * k), 32'hC0DE_0000 + 32'(k)}) begin
                errors++;
                $display("FAIL rst_prio_seq_%0d: got v=%b pc=%h d=%h want v=1 pc=%h d=%h",
                         k, Inst_valid, Inst_pc, Inst_data, 32'(4 * k),
                         32'hC0DE_0000 + 32'(k));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_full_redirect();
        test_reset_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
